jk_register_bank: RTL and testbench

//  WIDTH-bit bank of JK flip-flops with a shared clock, enable and mode select.
//  Per-bit JK operation, parallel load, and synchronous up/down counting built from the JK cells (J=K=toggle).

---
 rtl/jk_pkg.sv | 28 ++
 rtl/jk_cell.sv | 41 ++++
 rtl/jk_register_bank.sv | 99 +++++++++
 tb/tb_jk_register_bank.sv | 138 +++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared mode and per-bit action encodings for the JK register bank.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_MODE_JK   = 2'b00,
    JK_MODE_LOAD = 2'b01,
    JK_MODE_UP   = 2'b10,
    JK_MODE_DN   = 2'b11
  } jk_mode_e;

  // Action codes line up with {j,k} so JK mode can cast the pair directly.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_act_e;

  function automatic logic jk_next(input logic q, input jk_act_e act);
    case (act)
      JK_CLR:  return 1'b0;
      JK_SET:  return 1'b1;
      JK_TGL:  return ~q;
      default: return q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with enable, parallel load and a complement output
// registered from the same next-state value.
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  logic    load,
  input  logic    d,
  input  jk_act_e act,
  output logic    q,
  output logic    qbar
);

  logic q_q;
  logic qbar_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (load) q_d = d;
    else      q_d = jk_next(q_q, act);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q    <= RESET_VAL;
      qbar_q <= ~RESET_VAL;
    end else if (en) begin
      q_q    <= q_d;
      qbar_q <= ~q_d;
    end
  end

  assign q    = q_q;
  assign qbar = qbar_q;

endmodule

// File: rtl/jk_register_bank.sv
// WIDTH-bit bank of JK cells supporting per-bit JK, parallel load and
// up/down counting, with terminal-count decode and a sticky overflow flag.
module jk_register_bank
  import jk_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter bit                WRAP      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             ovf
);

  jk_mode_e         mode_e;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic             load_c;
  logic             count_c;
  logic             hold_term_c;
  logic             ovf_q;
  logic             ovf_d;
  jk_act_e          act [WIDTH];

  assign mode_e  = jk_mode_e'(mode);
  assign count_c = (mode_e == JK_MODE_UP) || (mode_e == JK_MODE_DN);
  assign load_c  = (mode_e == JK_MODE_LOAD);

  assign tc = ((mode_e == JK_MODE_UP) && (&q)) ||
              ((mode_e == JK_MODE_DN) && (~|q));

  // A saturating counter freezes every cell on the terminal step.
  assign hold_term_c = tc && !WRAP;

  // Ripple carry/borrow: bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    logic up_c;
    logic dn_c;
    up_t = '0;
    dn_t = '0;
    up_c = 1'b1;
    dn_c = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      up_t[i] = up_c;
      dn_t[i] = dn_c;
      up_c    = up_c & q[i];
      dn_c    = dn_c & ~q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      act[i] = JK_HOLD;
      case (mode_e)
        JK_MODE_JK: act[i] = jk_act_e'({j[i], k[i]});
        JK_MODE_UP: if (up_t[i] && !hold_term_c) act[i] = JK_TGL;
        JK_MODE_DN: if (dn_t[i] && !hold_term_c) act[i] = JK_TGL;
        default:    act[i] = JK_HOLD;
      endcase
    end
  end

  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
    jk_cell #(
      .RESET_VAL (RESET_VAL[gi])
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .load  (load_c),
      .d     (d[gi]),
      .act   (act[gi]),
      .q     (q[gi]),
      .qbar  (qbar[gi])
    );
  end

  always_comb begin
    ovf_d = ovf_q;
    if (load_c)             ovf_d = 1'b0;
    else if (count_c && tc) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset)  ovf_q <= 1'b0;
    else if (en) ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_jk_register_bank.sv
// Scoreboard bench: a wrapping and a saturating bank share stimulus; each
// step queues the expected post-edge state of one of them for the monitor.
module tb_jk_register_bank;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j, k, d;
  logic [W-1:0] qa, qbara, qb, qbarb;
  logic         tca, ovfa, tcb, ovfb;

  typedef struct {
    string        name;
    bit           sel;
    logic [W-1:0] q;
    logic         ovf;
    logic         tc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  jk_register_bank #(.WIDTH(W), .RESET_VAL(8'h00), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(qa), .qbar(qbara), .tc(tca), .ovf(ovfa)
  );

  jk_register_bank #(.WIDTH(W), .RESET_VAL(8'h00), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(qb), .qbar(qbarb), .tc(tcb), .ovf(ovfb)
  );

  task automatic check(input string name, input logic [W-1:0] act_v,
                       input logic [W-1:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  // Monitor: the bank presents a new state every edge; compare just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      check("qbar_wrap", qbara, ~qa);
      check("qbar_sat",  qbarb, ~qb);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (!e.sel) begin
          check({e.name, ".q"},    qa,   e.q);
          check({e.name, ".qbar"}, qbara, ~e.q);
          check({e.name, ".ovf"},  W'(ovfa), W'(e.ovf));
          check({e.name, ".tc"},   W'(tca),  W'(e.tc));
        end else begin
          check({e.name, ".q"},    qb,   e.q);
          check({e.name, ".qbar"}, qbarb, ~e.q);
          check({e.name, ".ovf"},  W'(ovfb), W'(e.ovf));
          check({e.name, ".tc"},   W'(tcb),  W'(e.tc));
        end
      end
    end
  end

  // Drive one cycle of stimulus and queue the expected post-edge state.
  task automatic step(input string name, input bit sel, input logic rst,
                      input logic en_v, input logic [1:0] mode_v,
                      input logic [W-1:0] j_v, input logic [W-1:0] k_v,
                      input logic [W-1:0] d_v, input logic [W-1:0] eq,
                      input logic eovf, input logic etc);
    exp_t e;
    reset = rst; en = en_v; mode = mode_v; j = j_v; k = k_v; d = d_v;
    e.name = name; e.sel = sel; e.q = eq; e.ovf = eovf; e.tc = etc;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  localparam logic [1:0] MJK = 2'b00, MLD = 2'b01, MUP = 2'b10, MDN = 2'b11;

  initial begin
    int budget;
    reset = 1'b0; en = 1'b1; mode = MUP; j = '0; k = '0; d = '0;
    // reset dominates enable and count mode
    step("rst0",    1'b0, 1'b0, 1'b1, MUP, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step("rst1",    1'b1, 1'b0, 1'b1, MUP, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step("rel",     1'b0, 1'b1, 1'b1, MUP, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
    // JK per-bit actions
    step("ld0f",    1'b0, 1'b1, 1'b1, MLD, 8'h00, 8'h00, 8'h0F, 8'h0F, 1'b0, 1'b0);
    step("jk",      1'b0, 1'b1, 1'b1, MJK, 8'hF0, 8'h3C, 8'hFF, 8'hF3, 1'b0, 1'b0);
    // load, count, hold
    step("lda5",    1'b0, 1'b1, 1'b1, MLD, 8'hFF, 8'hFF, 8'hA5, 8'hA5, 1'b0, 1'b0);
    step("up_a6",   1'b0, 1'b1, 1'b1, MUP, 8'hFF, 8'hFF, 8'h00, 8'hA6, 1'b0, 1'b0);
    step("up_a7",   1'b0, 1'b1, 1'b1, MUP, 8'hFF, 8'hFF, 8'h00, 8'hA7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("hold",  1'b0, 1'b1, 1'b0, MUP, 8'hFF, 8'h00, 8'h55, 8'hA7, 1'b0, 1'b0);
    // wrapping up-count terminal step
    step("ldfe",    1'b0, 1'b1, 1'b1, MLD, 8'h00, 8'h00, 8'hFE, 8'hFE, 1'b0, 1'b0);
    step("up_ff",   1'b0, 1'b1, 1'b1, MUP, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1);
    step("wrap_up", 1'b0, 1'b1, 1'b1, MUP, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step("ld10",    1'b0, 1'b1, 1'b1, MLD, 8'h00, 8'h00, 8'h10, 8'h10, 1'b0, 1'b0);
    // saturating down-count terminal step, then direction change
    step("s_ld01",  1'b1, 1'b1, 1'b1, MLD, 8'h00, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0);
    step("s_dn00",  1'b1, 1'b1, 1'b1, MDN, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    step("s_sat",   1'b1, 1'b1, 1'b1, MDN, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    step("s_tc_up", 1'b1, 1'b1, 1'b0, MUP, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step("s_up01",  1'b1, 1'b1, 1'b1, MUP, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    // wrapping down-count, JK keeps ovf, reset mid-count clears everything
    step("ld00",    1'b0, 1'b1, 1'b1, MLD, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1 & 1'b0);
    step("wrap_dn", 1'b0, 1'b1, 1'b1, MDN, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0);
    step("jk_7e",   1'b0, 1'b1, 1'b1, MJK, 8'h7E, 8'h81, 8'h00, 8'h7E, 1'b1, 1'b0);
    step("up_7f",   1'b0, 1'b1, 1'b1, MUP, 8'h00, 8'h00, 8'h00, 8'h7F, 1'b1, 1'b0);
    step("rst_mid", 1'b0, 1'b0, 1'b1, MUP, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step("resume",  1'b0, 1'b1, 1'b1, MUP, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
